// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, frame constants, parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic        PS2_START_BIT = 1'b0;
  localparam logic        PS2_STOP_BIT  = 1'b1;
  localparam int unsigned PS2_DATA_BITS = 8;

  // Odd parity: the running XOR of the data bits combined with the parity bit must be 1.
  function automatic logic ps2_parity_ok(input logic data_xor, input logic parity_bit);
    return (data_xor ^ parity_bit) == 1'b1;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Valid/ready byte queue for the PS/2 receiver.
// PS2_HOST_RX_FIFO_EN defined: 2**FIFO_BITS entries; undefined: single holding register.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overflow
);

  if (FIFO_BITS == 0 || FIFO_BITS > 16) begin : g_cfg_check
    $error("ps2_rx_fifo: FIFO_BITS must be in 1..16");
  end

`ifdef PS2_HOST_RX_FIFO_EN

  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam int unsigned PW    = FIFO_BITS + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              empty_c, full_c, do_pop_c, do_push_c;

  // Extra pointer bit distinguishes full from empty without sacrificing a slot.
  always_comb begin
    mem_d      = mem_q;
    empty_c    = (wr_ptr_q == rd_ptr_q);
    full_c     = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                 (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    do_pop_c   = pop && !empty_c;
    do_push_c  = push && (!full_c || do_pop_c);
    overflow_d = push && !do_push_c;
    if (do_push_c) begin
      mem_d[wr_ptr_q[FIFO_BITS-1:0]] = push_data;
    end
    wr_ptr_d   = wr_ptr_q + PW'(do_push_c);
    rd_ptr_d   = rd_ptr_q + PW'(do_pop_c);
    rd_valid_d = (wr_ptr_d != rd_ptr_d);
    rd_data_d  = mem_d[rd_ptr_d[FIFO_BITS-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

`else

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              do_pop_c, do_push_c;

  // Depth-1 holding register with the same accept/drop rule as the full FIFO.
  always_comb begin
    do_pop_c   = pop && rd_valid_q;
    do_push_c  = push && (!rd_valid_q || do_pop_c);
    overflow_d = push && !do_push_c;
    rd_valid_d = do_push_c || (rd_valid_q && !do_pop_c);
    rd_data_d  = do_push_c ? push_data : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: synchronise and filter the ps2 lines, deserialise 11-bit frames, queue good bytes.
// Queue depth selected by PS2_HOST_RX_FIFO_EN (2**FIFO_BITS entries) or a single register when undefined.
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_BITS  = 3,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned TO_W  = 16;
  localparam int unsigned CNT_W = $clog2(PS2_DATA_BITS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PS2_DATA_BITS - 1);

  logic [1:0]               clk_sync_q, clk_sync_d;
  logic [1:0]               data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0]    hist_q, hist_d;
  logic                     filt_q, filt_d;
  logic                     sample_c, bit_c, timeout_c;

  ps2_state_e               state_q, state_d;
  logic [CNT_W-1:0]         bitcnt_q, bitcnt_d;
  logic                     acc_q, acc_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_ok_q, par_ok_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic                     push_q, push_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     busy_q, busy_d;

  // Input synchronisers and clock glitch filter; a sample event is a filtered 1->0 edge.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    hist_d      = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d      = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end
    sample_c = filt_q && !filt_d;
    bit_c    = data_sync_q[1];
  end

  // Frame FSM with watchdog; results are registered so the push lands one cycle after STOP.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    acc_d        = acc_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    push_d       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST) && !sample_c;
    if (sample_c || state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (timeout_c) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (sample_c) begin
      case (state_q)
        ST_IDLE: begin
          if (bit_c == PS2_START_BIT) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
            acc_d    = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d  = {bit_c, shift_q[PS2_DATA_BITS-1:1]};
          acc_d    = acc_q ^ bit_c;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_ok_d = ps2_parity_ok(acc_q, bit_c);
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (bit_c != PS2_STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
          end else begin
            push_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      hist_q       <= '1;
      filt_q       <= 1'b1;
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      acc_q        <= 1'b0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      to_cnt_q     <= '0;
      push_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      hist_q       <= hist_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      acc_q        <= acc_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      to_cnt_q     <= to_cnt_d;
      push_q       <= push_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // shift_q is stable for the cycle push_q is high, so it feeds the queue directly.
  ps2_rx_fifo #(
    .FIFO_BITS (FIFO_BITS),
    .DATA_W    (PS2_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (rx_ready),
    .rd_data   (rx_data),
    .rd_valid  (rx_valid),
    .overflow  (overflow)
  );

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Self-checking bench for ps2_host_rx: frame-level reference model plus directed scenarios and random frames.
module tb_ps2_host_rx;

`ifdef PS2_HOST_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam int TIMEOUT = 10000;
  localparam int W       = 20;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk, ps2_data, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overflow, busy;

  always #5 clk = ~clk;

  ps2_host_rx #(
    .FIFO_BITS  (3),
    .FILTER_LEN (4),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  bit flux;
  int ready_pct;
  int half;
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  int cnt_par, cnt_frm, cnt_ovf;
  int exp_par, exp_frm, exp_ovf;
  int last_par, last_frm, last_ovf;
  bit model_busy;
  int mnb;
  logic [10:0] mfb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: collect bits after a start bit, judge the whole frame at the 11th.
  task automatic model_edge(input logic b);
    logic [7:0] d;
    if (mnb == 0 && b == 1'b1) return;
    mfb[mnb] = b;
    mnb++;
    if (mnb == 11) begin
      d = mfb[8:1];
      if (mfb[10] == 1'b0) exp_frm = 1;
      else if (^{mfb[9], d} != 1'b1) exp_par = 1;
      else if (mq.size() < DEPTH) mq.push_back(d);
      else exp_ovf = 1;
      mnb = 0;
    end
    model_busy = (mnb != 0);
  endtask

  task automatic open_flux();
    flux = 1'b1;
    cnt_par = 0; cnt_frm = 0; cnt_ovf = 0;
    exp_par = 0; exp_frm = 0; exp_ovf = 0;
  endtask

  task automatic close_flux();
    chk("parity_err_pulses", cnt_par, exp_par);
    chk("frame_err_pulses", cnt_frm, exp_frm);
    chk("overflow_pulses", cnt_ovf, exp_ovf);
    last_par = cnt_par; last_frm = cnt_frm; last_ovf = cnt_ovf;
    flux = 1'b0;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad);
    return {~stop_bad, (~(^d)) ^ par_bad, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      if (i == glitch_at) begin
        tick(half / 2);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(half - half / 2 - 2);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b0;
      open_flux();
      tick(W);
      model_edge(b[i]);
      close_flux();
      tick(half - W);
      ps2_clk = 1'b1;
    end
    tick(half);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad);
    send_bits(mk_frame(d, par_bad, stop_bad), 11, -1);
  endtask

  // Per-cycle compare and consumer; rx_ready is held low while the model is settling.
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && !flux) begin
        chk("rx_valid", rx_valid, mq.size() != 0);
        if (mq.size() != 0) chk("rx_data", rx_data, mq[0]);
        chk("busy", busy, model_busy);
        chk("parity_err_idle", parity_err, 0);
        chk("frame_err_idle", frame_err, 0);
        chk("overflow_idle", overflow, 0);
      end else if (reset_n) begin
        cnt_par += int'(parity_err);
        cnt_frm += int'(frame_err);
        cnt_ovf += int'(overflow);
      end
      if (reset_n && !flux && int'($urandom_range(99)) < ready_pct) begin
        rx_ready = 1'b1;
        if (mq.size() != 0) begin
          popped.push_back(rx_data);
          void'(mq.pop_front());
        end
      end else begin
        rx_ready = 1'b0;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovf_total;
    logic [7:0] d;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    flux = 1'b1; ready_pct = 0; half = 42; mnb = 0; model_busy = 1'b0;
    tick(3);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    tick(5);
    flux = 1'b0;
    tick(10);

    // Good frame 0x1C
    ready_pct = 100; popped.delete();
    send_frame(8'h1C, 1'b0, 1'b0);
    tick(10);
    chk("t1_count", popped.size(), 1);
    if (popped.size() != 0) chk("t1_data", popped[0], 8'h1C);
    chk("t1_errs", last_par + last_frm + last_ovf, 0);

    // 0x00 with parity bit 0 is a parity error
    send_frame(8'h00, 1'b1, 1'b0);
    tick(5);
    chk("t2_parity_err", last_par, 1);
    chk("t2_frame_err", last_frm, 0);
    chk("t2_rx_valid", rx_valid, 0);

    // Fill past capacity, then drain
    ready_pct = 0; popped.delete(); ovf_total = 0;
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b0, 1'b0);
      ovf_total += last_ovf;
    end
    chk("t3_overflows", ovf_total, 9 - DEPTH);
    ready_pct = 100;
    tick(30);
    chk("t3_drain_count", popped.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < popped.size(); i++) chk("t3_drain_data", popped[i], i + 1);

    // Truncated frame times out
    send_bits(mk_frame(8'h05, 1'b0, 1'b0), 4, -1);
    chk("t4_busy_mid", busy, 1);
    open_flux();
    tick(TIMEOUT + 100);
    exp_frm = 1; mnb = 0; model_busy = 1'b0;
    close_flux();
    chk("t4_frame_err", last_frm, 1);
    chk("t4_busy_after", busy, 0);
    popped.delete();
    send_frame(8'hAA, 1'b0, 1'b0);
    tick(10);
    chk("t4_next_count", popped.size(), 1);
    if (popped.size() != 0) chk("t4_next_data", popped[0], 8'hAA);

    // Short glitches are filtered out
    ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(20);
    chk("t5_idle_busy", busy, 0);
    popped.delete();
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 11, 4);
    tick(10);
    chk("t5_glitch_count", popped.size(), 1);
    if (popped.size() != 0) chk("t5_glitch_data", popped[0], 8'h3C);

    // Reset mid-frame with bytes queued
    ready_pct = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_bits(mk_frame(8'h33, 1'b0, 1'b0), 5, -1);
    flux = 1'b1;
    reset_n = 1'b0;
    tick(3);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_errs", {parity_err, frame_err, overflow}, 0);
    mq.delete(); mnb = 0; model_busy = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    flux = 1'b0;
    popped.delete(); ready_pct = 100;
    send_frame(8'h5A, 1'b0, 1'b0);
    tick(10);
    chk("t6_next_count", popped.size(), 1);
    if (popped.size() != 0) chk("t6_next_data", popped[0], 8'h5A);

    // Randomised frames, ps2 rates and consumer behaviour
    repeat (30) begin
      half = int'($urandom_range(30, 50));
      case ($urandom_range(2))
        0: ready_pct = 0;
        1: ready_pct = 50;
        default: ready_pct = 100;
      endcase
      d = 8'($urandom);
      send_frame(d, $urandom_range(99) < 15, $urandom_range(99) < 10);
      tick(int'($urandom_range(5, 200)));
    end

    ready_pct = 100; half = 42;
    tick(40);
    chk("final_model_empty", mq.size(), 0);
    chk("final_rx_valid", rx_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
